// File: rtl/trap_ctrl.sv
// Trap / return controller.
// Accepts illegal/ecall/ebreak/mret requests from decode, pulses the CSR
// write for traps, counts them, and steers fetch to mtvec or mepc.
module trap_ctrl #(
   parameter logic [31:0] ILLEGAL_CAUSE = 32'd2,
   parameter logic [31:0] EBREAK_CAUSE  = 32'd3,
   parameter logic [31:0] ECALL_CAUSE   = 32'd11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_kind,
   input  logic [31:0] req_pc,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   output logic        exception,
   output logic [31:0] exception_pc,
   output logic [31:0] exception_cause,
   output logic        redirect_valid,
   input  logic        redirect_ready,
   output logic [31:0] redirect_pc,
   output logic        busy,
   output logic [31:0] trap_count
);

   localparam logic [1:0] KIND_MRET = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      EXC   = 2'b01,
      REDIR = 2'b10
   } state_t;

   state_t      state;
   logic [31:0] req_cause;

   // Targets are word aligned, so the low two bits of the CSR values are dropped.
   logic unused_low_bits;
   assign unused_low_bits = ^{mtvec[1:0], mepc[1:0]};

   // Map the request kind onto the mcause value it reports.
   always_comb begin
      // NOTE: default first so every path assigns req_cause and no latch is inferred.
      req_cause = ILLEGAL_CAUSE;
      case (req_kind)
         2'b01:   req_cause = ECALL_CAUSE;
         2'b10:   req_cause = EBREAK_CAUSE;
         default: req_cause = ILLEGAL_CAUSE;
      endcase
   end

   // Controller state machine; every output is a flop updated with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
         state           <= IDLE;
         req_ready       <= 1'b1;
         busy            <= 1'b0;
         exception       <= 1'b0;
         exception_pc    <= 32'd0;
         exception_cause <= 32'd0;
         redirect_valid  <= 1'b0;
         redirect_pc     <= 32'd0;
         trap_count      <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (req_kind == KIND_MRET) begin
                     // mepc is captured here only; later CSR writes are irrelevant.
                     redirect_pc    <= {mepc[31:2], 2'b00};
                     redirect_valid <= 1'b1;
                     state          <= REDIR;
                  end else begin
                     exception_pc    <= req_pc;
                     exception_cause <= req_cause;
                     exception       <= 1'b1;
                     state           <= EXC;
                  end
               end
            end
            EXC: begin
               // Single-cycle CSR write; the vector is sampled in this cycle only.
               exception      <= 1'b0;
               trap_count     <= trap_count + 32'd1;
               redirect_pc    <= {mtvec[31:2], 2'b00};
               redirect_valid <= 1'b1;
               state          <= REDIR;
            end
            REDIR: begin
               // Hold the redirect until fetch takes it.
               if (redirect_ready) begin
                  redirect_valid <= 1'b0;
                  busy           <= 1'b0;
                  req_ready      <= 1'b1;
                  state          <= IDLE;
               end
            end
            default: begin
               exception      <= 1'b0;
               redirect_valid <= 1'b0;
               busy           <= 1'b0;
               req_ready      <= 1'b1;
               state          <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized
// request sequences compared against a transaction-level reference model.
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_kind;
   logic [31:0] req_pc;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic        exception;
   logic [31:0] exception_pc;
   logic [31:0] exception_cause;
   logic        redirect_valid;
   logic        redirect_ready;
   logic [31:0] redirect_pc;
   logic        busy;
   logic [31:0] trap_count;

   trap_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_kind        (req_kind),
      .req_pc          (req_pc),
      .mtvec           (mtvec),
      .mepc            (mepc),
      .exception       (exception),
      .exception_pc    (exception_pc),
      .exception_cause (exception_cause),
      .redirect_valid  (redirect_valid),
      .redirect_ready  (redirect_ready),
      .redirect_pc     (redirect_pc),
      .busy            (busy),
      .trap_count      (trap_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: architectural view only.
   logic [31:0] m_count;
   logic [31:0] m_last_pc;
   logic [31:0] m_last_cause;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cause_of(input logic [1:0] kind);
      if (kind == 2'b01) return 32'd11;
      if (kind == 2'b10) return 32'd3;
      return 32'd2;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_exception"},  {31'd0, exception}, 32'd0);
      check({tag, "_exc_pc"},     exception_pc, 32'd0);
      check({tag, "_exc_cause"},  exception_cause, 32'd0);
      check({tag, "_rvalid"},     {31'd0, redirect_valid}, 32'd0);
      check({tag, "_rpc"},        redirect_pc, 32'd0);
      check({tag, "_busy"},       {31'd0, busy}, 32'd0);
      check({tag, "_count"},      trap_count, 32'd0);
      check({tag, "_ready"},      {31'd0, req_ready}, 32'd1);
   endtask

   // One complete request: accept, optional EXC, REDIR with stall, handshake.
   task automatic run_req(input string tag, input logic [1:0] kind, input logic [31:0] pc,
                          input logic [31:0] tvec, input logic [31:0] epc, input int stall);
      logic        is_trap;
      logic [31:0] target;
      is_trap = (kind != 2'b11);
      target  = is_trap ? {tvec[31:2], 2'b00} : {epc[31:2], 2'b00};

      check({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_idle_busy"},  {31'd0, busy}, 32'd0);
      req_valid      = 1'b1;
      req_kind       = kind;
      req_pc         = pc;
      mtvec          = tvec;
      mepc           = epc;
      redirect_ready = $urandom_range(0, 1); // ignored while not redirecting
      step();
      req_valid = 1'b0;
      req_pc    = $urandom;
      mepc      = $urandom;

      if (is_trap) begin
         m_last_pc    = pc;
         m_last_cause = cause_of(kind);
         check({tag, "_exc_pulse"}, {31'd0, exception}, 32'd1);
         check({tag, "_exc_pc"},    exception_pc, m_last_pc);
         check({tag, "_exc_cause"}, exception_cause, m_last_cause);
         check({tag, "_exc_busy"},  {31'd0, busy}, 32'd1);
         check({tag, "_exc_ready"}, {31'd0, req_ready}, 32'd0);
         check({tag, "_exc_rvalid"},{31'd0, redirect_valid}, 32'd0);
         redirect_ready = 1'b0;
         step();
         m_count = m_count + 32'd1;
      end else begin
         redirect_ready = 1'b0;
      end

      check({tag, "_redir_valid"}, {31'd0, redirect_valid}, 32'd1);
      check({tag, "_redir_pc"},    redirect_pc, target);
      check({tag, "_redir_exc"},   {31'd0, exception}, 32'd0);
      check({tag, "_redir_count"}, trap_count, m_count);

      // Stall: CSR inputs wander and decode keeps trying to issue.
      for (int i = 0; i < stall; i++) begin
         mtvec     = $urandom;
         mepc      = $urandom;
         req_valid = 1'b1;
         req_kind  = 2'($urandom_range(0, 3));
         step();
         check({tag, "_stall_valid"}, {31'd0, redirect_valid}, 32'd1);
         check({tag, "_stall_pc"},    redirect_pc, target);
         check({tag, "_stall_exc"},   {31'd0, exception}, 32'd0);
         check({tag, "_stall_ready"}, {31'd0, req_ready}, 32'd0);
      end
      req_valid      = 1'b0;
      redirect_ready = 1'b1;
      step();
      redirect_ready = 1'b0;
      check({tag, "_done_valid"}, {31'd0, redirect_valid}, 32'd0);
      check({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_done_busy"},  {31'd0, busy}, 32'd0);
      check({tag, "_done_exc"},   {31'd0, exception}, 32'd0);
      check({tag, "_hold_pc"},    exception_pc, m_last_pc);
      check({tag, "_hold_cause"}, exception_cause, m_last_cause);
      check({tag, "_done_count"}, trap_count, m_count);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      step();
      m_count      = 32'd0;
      m_last_pc    = 32'd0;
      m_last_cause = 32'd0;
   endtask

   initial begin
      rst            = 1'b1;
      req_valid      = 1'b0;
      req_kind       = 2'b00;
      req_pc         = 32'd0;
      mtvec          = 32'd0;
      mepc           = 32'd0;
      redirect_ready = 1'b0;
      @(negedge clk);
      apply_reset();
      step();
      rst = 1'b0;
      check_reset_outputs("reset");
      step();
      check("post_reset_ready", {31'd0, req_ready}, 32'd1);

      // ecall to vector
      run_req("ecall", 2'b01, 32'h8000_0010, 32'h8000_0100, 32'h0, 0);
      // mret to aligned mepc
      run_req("mret", 2'b11, 32'h1234_5678, 32'h0, 32'h8000_0013, 0);
      // illegal with a 5-cycle fetch stall and competing requests
      run_req("illegal_stall", 2'b00, 32'h0000_4444, 32'h8000_0203, 32'h0, 5);
      // ebreak with a stall while mtvec changes
      run_req("ebreak", 2'b10, 32'hCAFE_F00C, 32'h0000_0100, 32'h0, 3);

      // Randomized sequence
      for (int n = 0; n < 30; n++)
         run_req("rand", 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 4)));

      // Reset during REDIR
      req_valid = 1'b1; req_kind = 2'b01; req_pc = 32'h0000_1000; mtvec = 32'h0000_2000;
      step();
      req_valid = 1'b0;
      step();
      check("pre_rst_redir", {31'd0, redirect_valid}, 32'd1);
      apply_reset();
      check_reset_outputs("rst_redir");
      rst = 1'b0;
      step();
      check("rst_redir_release_ready", {31'd0, req_ready}, 32'd1);

      // Reset during EXC: no further pulse afterwards
      req_valid = 1'b1; req_kind = 2'b10; req_pc = 32'h0000_3000;
      step();
      req_valid = 1'b0;
      check("pre_rst_exc", {31'd0, exception}, 32'd1);
      apply_reset();
      check_reset_outputs("rst_exc");
      rst = 1'b0;
      step();
      check("rst_exc_no_pulse", {31'd0, exception}, 32'd0);
      check("rst_exc_no_redir", {31'd0, redirect_valid}, 32'd0);

      // Counter wrap: preload all ones, next trap wraps to zero
      force dut.trap_count = 32'hFFFF_FFFF;
      #1;
      release dut.trap_count;
      m_count = 32'hFFFF_FFFF;
      step();
      check("preload_count", trap_count, 32'hFFFF_FFFF);
      run_req("wrap", 2'b00, 32'h0000_0040, 32'h0000_0080, 32'h0, 1);
      check("wrap_zero", trap_count, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter ILLEGAL_CAUSE, default 32'd2, mcause value for illegal-instruction traps.
REQ-002 Parameter EBREAK_CAUSE, default 32'd3, mcause value for ebreak traps.
REQ-003 Parameter ECALL_CAUSE, default 32'd11, mcause value for ecall traps (M-mode).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  decode stage presents a trap/return request.
REQ-007 req_ready  output  1  controller can accept a request this cycle.
REQ-008 req_kind  input  2  2'b00 illegal, 2'b01 ecall, 2'b10 ebreak, 2'b11 mret.
REQ-009 req_pc  input  32  PC of the requesting instruction.
REQ-010 mtvec  input  32  trap vector from the CSR file.
REQ-011 mepc  input  32  exception PC from the CSR file.
REQ-012 exception  output  1  one-cycle pulse instructing the CSR file to write mepc/mcause.
REQ-013 exception_pc  output  32  value for mepc; valid while exception=1.
REQ-014 exception_cause  output  32  value for mcause; valid while exception=1.
REQ-015 redirect_valid  output  1  fetch redirect request.
REQ-016 redirect_ready  input  1  fetch accepts the redirect.
REQ-017 redirect_pc  output  32  redirect target; stable while redirect_valid=1.
REQ-018 busy  output  1  high in any state other than IDLE; pipeline stalls on it.
REQ-019 trap_count  output  32  number of exception pulses issued since reset.

Function
REQ-020 FSM states SHALL be IDLE, EXC, REDIR.
REQ-021 req_ready SHALL equal 1 only in IDLE; handshake fires when req_valid & req_ready on a rising edge.
REQ-022 On accepting kind 00/01/10: latch req_pc into exception_pc, cause from REQ-001..003 into exception_cause, go to EXC.
REQ-023 On accepting kind 11 (mret): latch {mepc[31:2],2'b00} into redirect_pc, go to REDIR; no exception pulse, trap_count unchanged.
REQ-024 In EXC: exception=1 for exactly one cycle; trap_count increments by 1 (wraps 32'hFFFFFFFF -> 0); latch {mtvec[31:2],2'b00} into redirect_pc; go to REDIR.
REQ-025 In REDIR: redirect_valid=1; redirect_pc held constant; on redirect_ready=1 go to IDLE next cycle.
REQ-026 redirect_valid SHALL NOT drop before redirect_ready is seen; redirect_ready while redirect_valid=0 is ignored.
REQ-027 Latency: trap accepted at edge N -> exception=1 during cycle N+1 -> redirect_valid=1 from cycle N+2; mret accepted at N -> redirect_valid=1 from N+1.
REQ-028 Minimum request-to-request spacing: next req_ready=1 in the cycle after the redirect handshake edge.
REQ-029 Requests presented while busy=1 SHALL be ignored (not queued).
REQ-030 exception_pc/exception_cause SHALL hold last latched values outside EXC.
REQ-031 mtvec is sampled only during EXC and mepc only at mret acceptance; later changes do not alter redirect_pc.
REQ-032 exception SHALL be 0 in IDLE and REDIR.

Reset
REQ-033 rst=1 at a rising edge SHALL force state IDLE from any state, including mid-EXC or mid-REDIR, with no further exception pulse.
REQ-034 Reset values: exception=0, exception_pc=0, exception_cause=0, redirect_valid=0, redirect_pc=0, busy=0, trap_count=0; req_ready=1 in the first cycle after reset release.

Verification
REQ-035 ecall req_pc=32'h8000_0010, mtvec=32'h8000_0100, redirect_ready=1 -> exception pulse cause=11 pc=32'h8000_0010 at N+1; redirect_pc=32'h8000_0100 at N+2; trap_count=1.
REQ-036 mret with mepc=32'h8000_0013 -> redirect_valid at N+1, redirect_pc=32'h8000_0010, no exception pulse, trap_count unchanged.
REQ-037 illegal trap with redirect_ready=0 for 5 cycles -> redirect_valid held 5 cycles, redirect_pc constant, second req_valid during stall ignored.
REQ-038 mtvec changed to 32'h0000_0200 during REDIR -> redirect_pc keeps value latched in EXC.
REQ-039 rst asserted during REDIR -> next cycle all outputs at reset values, req_ready=1 after release.
REQ-040 trap_count preloaded via 2^32-1 traps (or forced) -> next trap wraps to 0.
